// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run controller for simulation benches.
//
// The bench's clock and reset come in here. This block holds the core in reset
// for RST_CYCLES cycles and counts the cycles of the run. It watches the core's
// IO write port for a write to HALT_ADDR, which ends the program. A cycle-based
// watchdog ends runs that never halt. Every output is registered.
//
// Ports:
//   clk        in   bench clock; all logic is on the rising edge
//   rst        in   synchronous, active-high reset
//   io_we      in   core IO write strobe
//   io_addr    in   core IO write address (ADDR_WIDTH)
//   io_din     in   core IO write data (8)
//   core_rst   out  reset to the core; also high after halt or timeout
//   running    out  high while the core runs
//   cycle_cnt  out  run cycles elapsed (CNT_WIDTH); saturates at all-ones
//   done       out  sticky; the program halted or timed out
//   timed_out  out  sticky; the watchdog fired
//   exit_code  out  io_din captured by the halt write
//   halt_pulse out  one-cycle pulse on the halt capture
module sim_run_ctrl #(
  parameter int unsigned                  RST_CYCLES     = 3,
  parameter int unsigned                  TIMEOUT_CYCLES = 150000000,
  parameter int unsigned                  CNT_WIDTH      = 32,
  parameter int unsigned                  ADDR_WIDTH     = 32,
  parameter logic        [ADDR_WIDTH-1:0] HALT_ADDR      = 32'h00030004
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  io_we,
  input  logic [ADDR_WIDTH-1:0] io_addr,
  input  logic [7:0]            io_din,
  output logic                  core_rst,
  output logic                  running,
  output logic [CNT_WIDTH-1:0]  cycle_cnt,
  output logic                  done,
  output logic                  timed_out,
  output logic [7:0]            exit_code,
  output logic                  halt_pulse
);

  localparam int unsigned RstCntW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
  localparam logic [RstCntW-1:0] RstLast = RstCntW'(RST_CYCLES - 1);
  // The watchdog fires on the last cycle before the limit. The ternary stops an
  // underflow when the watchdog is disabled.
  localparam logic [CNT_WIDTH-1:0] WdLast =
      (TIMEOUT_CYCLES != 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit WdEn = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {StReset, StRun, StHalted, StTimeout} state_e;

  state_e               state_q, state_d;
  logic [RstCntW-1:0]   rst_cnt_q, rst_cnt_d;
  logic                 core_rst_q, core_rst_d;
  logic                 running_q, running_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic                 done_q, done_d;
  logic                 timed_out_q, timed_out_d;
  logic [7:0]           exit_code_q, exit_code_d;
  logic                 halt_pulse_q, halt_pulse_d;

  logic halt_hit;
  logic cnt_full;

  assign halt_hit = io_we && (io_addr == HALT_ADDR);
  assign cnt_full = &cycle_cnt_q;

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    core_rst_d   = core_rst_q;
    running_d    = running_q;
    cycle_cnt_d  = cycle_cnt_q;
    done_d       = done_q;
    timed_out_d  = timed_out_q;
    exit_code_d  = exit_code_q;
    halt_pulse_d = 1'b0;

    unique case (state_q)
      StReset: begin
        core_rst_d  = 1'b1;
        running_d   = 1'b0;
        cycle_cnt_d = '0;
        rst_cnt_d   = rst_cnt_q + 1'b1;
        if (rst_cnt_q == RstLast) begin
          state_d    = StRun;
          rst_cnt_d  = '0;
          core_rst_d = 1'b0;
          running_d  = 1'b1;
        end
      end
      StRun: begin
        // The halt cycle and the watchdog cycle are both counted.
        if (!cnt_full) begin
          cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
        if (halt_hit) begin
          // A halt on the watchdog's final cycle wins.
          state_d      = StHalted;
          exit_code_d  = io_din;
          done_d       = 1'b1;
          halt_pulse_d = 1'b1;
          core_rst_d   = 1'b1;
          running_d    = 1'b0;
        end else if (WdEn && (cycle_cnt_q == WdLast)) begin
          state_d     = StTimeout;
          done_d      = 1'b1;
          timed_out_d = 1'b1;
          core_rst_d  = 1'b1;
          running_d   = 1'b0;
        end
      end
      StHalted, StTimeout: begin
        // Terminal until rst. The core stays frozen and IO writes are ignored.
        core_rst_d = 1'b1;
        running_d  = 1'b0;
      end
      default: begin
        state_d    = StReset;
        rst_cnt_d  = '0;
        core_rst_d = 1'b1;
        running_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StReset;
      rst_cnt_q    <= '0;
      core_rst_q   <= 1'b1;
      running_q    <= 1'b0;
      cycle_cnt_q  <= '0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      exit_code_q  <= '0;
      halt_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      core_rst_q   <= core_rst_d;
      running_q    <= running_d;
      cycle_cnt_q  <= cycle_cnt_d;
      done_q       <= done_d;
      timed_out_q  <= timed_out_d;
      exit_code_q  <= exit_code_d;
      halt_pulse_q <= halt_pulse_d;
    end
  end

  assign core_rst   = core_rst_q;
  assign running    = running_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign done       = done_q;
  assign timed_out  = timed_out_q;
  assign exit_code  = exit_code_q;
  assign halt_pulse = halt_pulse_q;

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
- Synthesizable run controller for simulation benches.
- Replaces the fixed clock/reset/timeout initial blocks: sequences core reset for a configurable number of cycles, counts run cycles and detects program end via a halt write on the CPU IO bus.
- Enforces a cycle-based watchdog and reports exit code and status to the bench.
- Sits between the bench's clock/reset and riscv_top; it drives the core's reset and snoops its IO write port.

Parameters:
- RST_CYCLES, 3, cycles core_rst is held after rst deasserts; legal range ≥1.
- TIMEOUT_CYCLES, 150000000, run-cycle watchdog limit; 0 disables the watchdog.
- CNT_WIDTH, 32, width of the cycle counter; must hold TIMEOUT_CYCLES.
- ADDR_WIDTH, 32, IO address width.
- HALT_ADDR, 32'h00030004, IO address whose write ends the program.

Ports:
- clk  in  1  bench clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- io_we  in  1  core IO write strobe.
- io_addr  in  ADDR_WIDTH  core IO write address.
- io_din  in  8  core IO write data.
- core_rst  out  1  reset to riscv_top, registered.
- running  out  1  high while in RUN.
- cycle_cnt  out  CNT_WIDTH  run cycles elapsed.
- done  out  1  sticky; program halted or timed out.
- timed_out  out  1  sticky; watchdog fired.
- exit_code  out  8  io_din captured on halt.
- halt_pulse  out  1  one-cycle pulse on halt capture.

Behaviour:
- States: RESET, RUN, HALTED, TIMEOUT. All outputs are registered.
- rst=1 sampled:
  - next state RESET, rst_cnt=0.
  - core_rst=1, running=0, cycle_cnt=0, done=0, timed_out=0, exit_code=0, halt_pulse=0.
  - rst has priority over everything in every state, including mid-run and after done.
- RESET with rst=0:
  - rst_cnt increments each cycle.
  - When rst_cnt==RST_CYCLES-1, go to RUN.
  - core_rst therefore stays high for exactly RST_CYCLES edges after the first edge sampling rst=0, then drops in the same cycle running rises.
- RUN:
  - Every cycle: cycle_cnt += 1.
  - cycle_cnt reads 0 in the first RUN cycle.
- Halt:
  - Condition: in RUN, io_we=1 and io_addr==HALT_ADDR (full-width compare).
  - Next state HALTED; exit_code<=io_din; done<=1; halt_pulse<=1 for one cycle.
  - cycle_cnt includes the halt cycle.
- Watchdog:
  - Condition: in RUN, TIMEOUT_CYCLES≠0, no halt this cycle, cycle_cnt==TIMEOUT_CYCLES-1.
  - Next state TIMEOUT; done<=1; timed_out<=1; cycle_cnt reaches TIMEOUT_CYCLES.
- Simultaneous halt and watchdog: halt wins; timed_out stays 0.
- HALTED/TIMEOUT:
  - Sticky until rst.
  - core_rst=1 (core frozen), running=0, cycle_cnt frozen.
  - Further io writes are ignored.
- Writes outside RUN (including during RESET) are ignored.
- Writes in RUN to any other address have no effect.
- cycle_cnt never wraps: the watchdog fires first. With the watchdog disabled it saturates at all-ones.

Test Plan (RST_CYCLES=3, TIMEOUT_CYCLES=10):
- Reset sequence: rst=1 for 2 cycles, then 0 → core_rst=1 for 3 edges after release, then 0. running=1 in that same cycle, cycle_cnt=0, done=0.
- Halt: io_we=1, io_addr=0x30004, io_din=0x2A while cycle_cnt=5 → next cycle done=1, exit_code=0x2A, cycle_cnt=6, core_rst=1, halt_pulse high exactly one cycle, timed_out=0.
- Watchdog: no IO writes → after 10 RUN cycles timed_out=1, done=1, cycle_cnt=10, core_rst=1, exit_code=0.
- Tie: halt write while cycle_cnt=9 → HALTED, done=1, timed_out=0, cycle_cnt=10.
- Ignored writes:
  - io_addr=0x30000 in RUN → no state change.
  - halt write during RESET → no state change, exit_code=0.
  - halt write after done → exit_code unchanged.
- Mid-run reset: rst=1 at cycle_cnt=4 → next cycle core_rst=1, cycle_cnt=0, done=0. After release, the full 3-cycle reset sequence repeats and the run restarts.
